// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared constants, command op codes, sequencer state encoding
//                and the command legality check for the matrix memory
//                sequencer.
//  Contents    : ELEM_W, N_MAX, ADDR_W, MAT_W, OP_* codes, state_t,
//                cmd_legal()
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N_MAX  = 5;
    localparam int ADDR_W = 9;
    localparam int MAT_W  = N_MAX * N_MAX * ELEM_W;

    localparam logic [1:0] OP_LOAD_A  = 2'b00;
    localparam logic [1:0] OP_LOAD_B  = 2'b01;
    localparam logic [1:0] OP_STORE_C = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_STEP   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // A command is legal when the op is not the reserved code and the
    // dimension lies in 2..N_MAX.
    function automatic logic cmd_legal(input logic [1:0] op, input logic [2:0] size);
        return (op != 2'b11) && (size >= 3'd2) && (size <= 3'(N_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_index_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mat_index_gen
//  Description : Row-major (r,c) element walker for an n x n transfer.
//                Tracks the current register slice index (r*N_MAX+c) and the
//                packed memory offset (r*n+c), and provides the values for
//                the element after the current one.
//  Ports       : clk, reset      - clock, async active-high reset
//                load, size      - restart at (0,0) with dimension size
//                step            - advance to the next element
//                last            - current element is (n-1,n-1)
//                slice           - slice index of the current element
//                slice_nxt       - slice index of the next element
//                offset_nxt      - memory offset of the next element
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_index_gen #(
    parameter int N_MAX = 5,
    parameter int CNT_W = 3,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] size,
    output logic             last,
    output logic [IDX_W-1:0] slice,
    output logic [IDX_W-1:0] slice_nxt,
    output logic [IDX_W-1:0] offset_nxt
);

    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [IDX_W-1:0] r_slice;
    logic [IDX_W-1:0] r_offset;
    logic             w_row_end;

    assign w_row_end  = (r_col == r_n - CNT_W'(1));
    assign last       = w_row_end && (r_row == r_n - CNT_W'(1));
    assign slice      = r_slice;
    // Packed memory layout: the offset simply increments every element.
    assign offset_nxt = r_offset + IDX_W'(1);
    // Register layout has a fixed N_MAX stride: at the end of a row, skip
    // the (N_MAX - n) unused columns.
    assign slice_nxt  = w_row_end ? (r_slice + IDX_W'(N_MAX + 1) - IDX_W'(r_n))
                                  : (r_slice + IDX_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n      <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_slice  <= '0;
            r_offset <= '0;
        end else if (load) begin
            r_n      <= size;
            r_row    <= '0;
            r_col    <= '0;
            r_slice  <= '0;
            r_offset <= '0;
        end else if (step) begin
            if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + CNT_W'(1);
            end else begin
                r_col <= r_col + CNT_W'(1);
            end
            r_slice  <= slice_nxt;
            r_offset <= offset_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mem_sequencer
//  Description : Expands one block-transfer command into row-major per-element
//                start/done transactions on the matrix memory port. Loads
//                fill matrix_a or matrix_b; stores write a snapshot of
//                matrix_c back to memory.
//  Ports       : clk, reset                 - clock, async active-high reset
//                cmd_valid/cmd_ready        - command handshake
//                cmd_op, cmd_size, cmd_base - op code, dimension n, base addr
//                mem_start/mem_done         - per-element transaction handshake
//                mem_wr, mem_addr           - direction and element address
//                mem_wdata / mem_rdata      - write / read data
//                matrix_a, matrix_b         - operand registers
//                matrix_c                   - ALU result to store
//                busy, done, err            - status; done/err are pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mem_sequencer #(
    parameter int ELEM_W = matrix_pkg::ELEM_W,
    parameter int N_MAX  = matrix_pkg::N_MAX,
    parameter int ADDR_W = matrix_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [2:0]                    cmd_size,
    input  logic [ADDR_W-1:0]             cmd_base,
    output logic                          mem_start,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [ELEM_W-1:0]             mem_wdata,
    input  logic [ELEM_W-1:0]             mem_rdata,
    input  logic                          mem_done,
    output logic [N_MAX*N_MAX*ELEM_W-1:0] matrix_a,
    output logic [N_MAX*N_MAX*ELEM_W-1:0] matrix_b,
    input  logic [N_MAX*N_MAX*ELEM_W-1:0] matrix_c,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    import matrix_pkg::*;

    localparam int MAT_BITS = N_MAX * N_MAX * ELEM_W;
    localparam int BIT_W    = $clog2(MAT_BITS);
    localparam int IDX_W    = $clog2(N_MAX * N_MAX + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_op;
    logic [ADDR_W-1:0]     r_base;
    logic [MAT_BITS-1:0]   r_snap;
    logic [MAT_BITS-1:0]   r_matrix_a;
    logic [MAT_BITS-1:0]   r_matrix_b;
    logic                  r_mem_start;
    logic                  r_mem_wr;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [ELEM_W-1:0]     r_mem_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_start;
    logic                  w_elem_done;
    logic                  w_advance;
    logic                  w_last;
    logic [IDX_W-1:0]      w_slice;
    logic [IDX_W-1:0]      w_slice_nxt;
    logic [IDX_W-1:0]      w_offset_nxt;
    logic [BIT_W-1:0]      w_cur_bit;
    logic [BIT_W-1:0]      w_nxt_bit;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign w_accept    = cmd_valid && (r_state == ST_IDLE);
    assign w_legal     = cmd_legal(cmd_op, cmd_size);
    assign w_start     = w_accept && w_legal;
    assign w_elem_done = (r_state == ST_ACCESS) && mem_done;
    // Leaving STEP towards the next element (not the last one).
    assign w_advance   = (r_state == ST_STEP) && !w_last;
    assign w_cur_bit   = BIT_W'(w_slice) * BIT_W'(ELEM_W);
    assign w_nxt_bit   = BIT_W'(w_slice_nxt) * BIT_W'(ELEM_W);

    mat_index_gen #(
        .N_MAX (N_MAX),
        .CNT_W (3),
        .IDX_W (IDX_W)
    ) u_index_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (w_start),
        .step       (r_state == ST_STEP),
        .size       (cmd_size),
        .last       (w_last),
        .slice      (w_slice),
        .slice_nxt  (w_slice_nxt),
        .offset_nxt (w_offset_nxt)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start)  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (mem_done) w_state_nxt = ST_STEP;
            ST_STEP:   w_state_nxt = w_last ? ST_FINISH : ST_ACCESS;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and status outputs, registered from the next state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_start <= (w_state_nxt == ST_ACCESS);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_FINISH);
            r_err       <= w_accept && !w_legal;
        end
    end

    // ------------------------------------------------------------------
    // Command capture and memory port address/data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= OP_LOAD_A;
            r_base      <= '0;
            r_snap      <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_start) begin
            r_op       <= cmd_op;
            r_base     <= cmd_base;
            r_mem_wr   <= (cmd_op == OP_STORE_C);
            r_mem_addr <= cmd_base;
            if (cmd_op == OP_STORE_C) begin
                // The snapshot decouples the store from later ALU updates;
                // element (0,0) is taken straight from matrix_c since the
                // snapshot is only written on this same edge.
                r_snap      <= matrix_c;
                r_mem_wdata <= matrix_c[ELEM_W-1:0];
            end
        end else if (w_advance) begin
            // Address arithmetic wraps modulo 2^ADDR_W by truncation.
            r_mem_addr <= r_base + ADDR_W'(w_offset_nxt);
            if (r_op == OP_STORE_C) begin
                r_mem_wdata <= r_snap[w_nxt_bit +: ELEM_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand registers: cleared on accept, filled one slice per element
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_matrix_a <= '0;
        end else if (w_start && (cmd_op == OP_LOAD_A)) begin
            r_matrix_a <= '0;
        end else if (w_elem_done && (r_op == OP_LOAD_A)) begin
            r_matrix_a[w_cur_bit +: ELEM_W] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_matrix_b <= '0;
        end else if (w_start && (cmd_op == OP_LOAD_B)) begin
            r_matrix_b <= '0;
        end else if (w_elem_done && (r_op == OP_LOAD_B)) begin
            r_matrix_b[w_cur_bit +: ELEM_W] <= mem_rdata;
        end
    end

    assign mem_start = r_mem_start;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign matrix_a  = r_matrix_a;
    assign matrix_b  = r_matrix_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_mem_sequencer
//  Description : Self-checking bench for matrix_mem_sequencer. A negedge
//                process models the memory (byte at address a = a[7:0],
//                programmable latency) and monitors done/err pulses against
//                expectations queued by the stimulus process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mem_sequencer;

    localparam int MAT_W = 200;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_size;
    logic [8:0]       cmd_base;
    logic             mem_start;
    logic             mem_wr;
    logic [8:0]       mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;
    logic             mem_done;
    logic [MAT_W-1:0] matrix_a;
    logic [MAT_W-1:0] matrix_b;
    logic [MAT_W-1:0] matrix_c;
    logic             busy;
    logic             done;
    logic             err;

    matrix_mem_sequencer #(
        .ELEM_W (8),
        .N_MAX  (5),
        .ADDR_W (9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_size  (cmd_size),
        .cmd_base  (cmd_base),
        .mem_start (mem_start),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .matrix_c  (matrix_c),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    typedef struct {
        int               rel;
        bit               is_load;
        bit               sel_b;
        logic [MAT_W-1:0] val;
    } exp_done_t;

    exp_done_t   done_q[$];
    int          err_q[$];
    logic [16:0] wr_q[$];

    int n_chk     = 0;
    int n_pass    = 0;
    int t         = 0;
    int acc_t     = 0;
    int n_txn     = 0;
    int xfer_txn  = 0;
    int cnt       = 0;
    int low_run   = 0;
    int lat_fixed = 1;
    bit lat_alt   = 1'b0;
    bit spur      = 1'b0;
    bit prev_start = 1'b0;

    task automatic chk(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [MAT_W-1:0] exp_load(input int n, input logic [8:0] base);
        logic [MAT_W-1:0] v;
        logic [8:0]       a;
        v = '0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                a = base + 9'(r * n + c);
                v[(r * 5 + c) * 8 +: 8] = a[7:0];
            end
        end
        return v;
    endfunction

    task automatic push_done(input int rel, input bit is_load, input bit sel_b, input logic [MAT_W-1:0] val);
        exp_done_t e;
        e.rel = rel; e.is_load = is_load; e.sel_b = sel_b; e.val = val;
        done_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] sz, input logic [8:0] base, input bit hold);
        cmd_op = op; cmd_size = sz; cmd_base = base; cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, MAT_W'(busy), MAT_W'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Memory model and output monitor, all on the falling edge.
    initial begin
        exp_done_t e;
        int        lat;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            t++;
            if (reset) begin
                mem_done = 1'b0; cnt = 0; prev_start = 1'b0; low_run = 0;
            end else begin
                if (done) begin
                    if (done_q.size() == 0) chk("done_unexpected", MAT_W'(done), MAT_W'(0));
                    else begin
                        e = done_q.pop_front();
                        chk("done_cycle", MAT_W'(t - acc_t), MAT_W'(e.rel));
                        if (e.is_load && e.sel_b) chk("matrix_b", matrix_b, e.val);
                        else if (e.is_load)       chk("matrix_a", matrix_a, e.val);
                    end
                end
                if (err) begin
                    if (err_q.size() == 0) chk("err_unexpected", MAT_W'(err), MAT_W'(0));
                    else chk("err_cycle", MAT_W'(t - acc_t), MAT_W'(err_q.pop_front()));
                end
                if (cmd_valid && cmd_ready) begin
                    acc_t = t; xfer_txn = 0;
                end
                if (mem_start) begin
                    if (!prev_start) begin
                        n_txn++;
                        if (xfer_txn > 0) chk("start_gap", MAT_W'(low_run), MAT_W'(1));
                        xfer_txn++;
                        cnt = 0;
                    end
                    cnt++;
                    low_run = 0;
                    lat = lat_alt ? ((xfer_txn % 2 == 1) ? 1 : 4) : lat_fixed;
                    if (cnt == lat) begin
                        mem_done = 1'b1;
                        if (mem_wr) begin
                            if (wr_q.size() == 0) chk("wr_unexpected", MAT_W'(mem_wr), MAT_W'(0));
                            else chk("wr_addr_data", MAT_W'({mem_addr, mem_wdata}), MAT_W'(wr_q.pop_front()));
                        end else begin
                            mem_rdata = mem_addr[7:0];
                        end
                    end else begin
                        mem_done = 1'b0;
                    end
                end else begin
                    mem_done = spur;
                    cnt = 0;
                    low_run++;
                end
                prev_start = mem_start;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int               saved;
        int               k;
        logic [MAT_W-1:0] snap_a;
        logic [1:0]       rj_op[3];
        logic [2:0]       rj_sz[3];

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0; cmd_base = '0;
        matrix_c = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        chk("rst_cmd_ready", MAT_W'(cmd_ready), MAT_W'(1));
        chk("rst_busy",      MAT_W'(busy),      MAT_W'(0));
        chk("rst_mem_start", MAT_W'(mem_start), MAT_W'(0));
        chk("rst_mem_wr",    MAT_W'(mem_wr),    MAT_W'(0));
        chk("rst_mem_addr",  MAT_W'(mem_addr),  MAT_W'(0));
        chk("rst_mem_wdata", MAT_W'(mem_wdata), MAT_W'(0));
        chk("rst_done",      MAT_W'(done),      MAT_W'(0));
        chk("rst_err",       MAT_W'(err),       MAT_W'(0));
        chk("rst_matrix_a",  matrix_a,          MAT_W'(0));
        chk("rst_matrix_b",  matrix_b,          MAT_W'(0));

        // Spurious mem_done while idle
        saved = n_txn;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(posedge clk); #1;
        chk("spur_busy",     MAT_W'(busy),          MAT_W'(0));
        chk("spur_txn",      MAT_W'(n_txn - saved), MAT_W'(0));
        chk("spur_matrix_a", matrix_a,              MAT_W'(0));

        // Load A, n=3, base 0x010, L=1: done in cycle 19
        lat_fixed = 1;
        push_done(19, 1'b1, 1'b0, exp_load(3, 9'h010));
        send_cmd(2'b00, 3'd3, 9'h010, 1'b0);
        wait_idle("loadA_idle");

        // Rejected commands
        snap_a = matrix_a;
        saved  = n_txn;
        rj_op[0] = 2'b00; rj_sz[0] = 3'd6;
        rj_op[1] = 2'b01; rj_sz[1] = 3'd1;
        rj_op[2] = 2'b11; rj_sz[2] = 3'd3;
        for (int i = 0; i < 3; i++) begin
            err_q.push_back(1);
            send_cmd(rj_op[i], rj_sz[i], 9'h040, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            chk("reject_busy", MAT_W'(busy), MAT_W'(0));
        end
        chk("reject_txn",      MAT_W'(n_txn - saved),  MAT_W'(0));
        chk("reject_matrix_a", matrix_a,               snap_a);
        chk("reject_err_left", MAT_W'(err_q.size()),   MAT_W'(0));

        // Store C, n=5, base 0x1F0 (wraps), L=2, matrix_c changed mid-transfer
        lat_fixed = 2;
        for (int i = 0; i < 25; i++) matrix_c[i * 8 +: 8] = 8'(i + 1);
        for (int i = 0; i < 25; i++) wr_q.push_back({9'(9'h1F0 + 9'(i)), 8'(i + 1)});
        push_done(76, 1'b0, 1'b0, MAT_W'(0));
        send_cmd(2'b10, 3'd5, 9'h1F0, 1'b0);
        repeat (10) @(posedge clk);
        #1 matrix_c = '1;
        wait_idle("store_idle");
        chk("store_wr_left", MAT_W'(wr_q.size()), MAT_W'(0));

        // Load B, n=2, base 0x1FE, L alternating 1/4, cmd_valid held high
        lat_alt = 1'b1;
        saved   = n_txn;
        push_done(15, 1'b1, 1'b1, exp_load(2, 9'h1FE));
        send_cmd(2'b01, 3'd2, 9'h1FE, 1'b1);
        cmd_op = 2'b00; cmd_size = 3'd3; cmd_base = 9'h000;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        cmd_valid = 1'b0;
        wait_idle("loadB_idle");
        lat_alt = 1'b0;
        chk("loadB_txns",     MAT_W'(n_txn - saved), MAT_W'(4));
        chk("held_matrix_a",  matrix_a,              snap_a);

        // Reset during ACCESS of element 4 of an n=4 load
        lat_fixed = 3;
        saved = n_txn;
        send_cmd(2'b00, 3'd4, 9'h020, 1'b0);
        k = 0;
        while ((n_txn - saved) < 5 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_elem4_reached", MAT_W'(n_txn - saved), MAT_W'(5));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mem_start", MAT_W'(mem_start), MAT_W'(0));
        chk("midrst_busy",      MAT_W'(busy),      MAT_W'(0));
        chk("midrst_matrix_a",  matrix_a,          MAT_W'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // New command after the reset
        lat_fixed = 1;
        push_done(9, 1'b1, 1'b0, exp_load(2, 9'h080));
        send_cmd(2'b00, 3'd2, 9'h080, 1'b0);
        wait_idle("post_rst_idle");

        chk("done_left", MAT_W'(done_q.size()), MAT_W'(0));
        chk("err_left",  MAT_W'(err_q.size()),  MAT_W'(0));
        chk("wr_left",   MAT_W'(wr_q.size()),   MAT_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
